// File: rtl/bram_mp.sv
// bram_mp: parametrised multi-port block RAM with a hardware init sweep.
//
// After reset the array is filled with word i = OFS + i*INCR (truncated to
// WIDTH), one word per clock. Requests are ignored until the sweep completes.
// Per port, re beats we beats ld. Simultaneous writers to one address store
// the highest-index port's data and raise a one-cycle collision pulse.
//
// Optional build macro BRAM_FWD_EN: a read that hits an address being written
// by another port in the same cycle returns the new (stored) data. Without it
// reads are read-first and no forwarding mux exists.
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   o_init_busy  high while the init sweep runs; requests ignored
//   i_re/i_we/i_ld  per-port read / write / load enables
//   i_raddr/i_waddr per-port addresses, port p at [p*ADDR +: ADDR]
//   i_wi/i_ri       per-port write data / load value, port p at [p*WIDTH +: WIDTH]
//   o_dout          per-port registered data out
//   o_dvalid        per-port strobe: o_dout slice updated on the last edge
//   o_collision     pulse: two or more ports wrote one address on the last edge
module bram_mp #(
  parameter int unsigned       DEPTH = 1024,
  parameter int unsigned       WIDTH = 36,
  parameter int unsigned       PORTS = 2,
  parameter logic [WIDTH-1:0]  OFS   = '0,
  parameter logic [WIDTH-1:0]  INCR  = '0,
  localparam int unsigned      ADDR  = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  output logic                   o_init_busy,
  input  logic [PORTS-1:0]       i_re,
  input  logic [PORTS-1:0]       i_we,
  input  logic [PORTS-1:0]       i_ld,
  input  logic [PORTS*ADDR-1:0]  i_raddr,
  input  logic [PORTS*ADDR-1:0]  i_waddr,
  input  logic [PORTS*WIDTH-1:0] i_wi,
  input  logic [PORTS*WIDTH-1:0] i_ri,
  output logic [PORTS*WIDTH-1:0] o_dout,
  output logic [PORTS-1:0]       o_dvalid,
  output logic                   o_collision
);

  typedef enum logic {StInit, StRun} state_e;

  state_e           r_state, w_state_d;
  logic [ADDR-1:0]  r_ptr;
  logic [WIDTH-1:0] r_fill;  // running OFS + ptr*INCR, avoids a multiplier
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [WIDTH-1:0] r_dout [PORTS];
  logic [PORTS-1:0] r_dvalid;
  logic             r_collision;

  logic             w_run;
  logic [ADDR-1:0]  w_raddr [PORTS];
  logic [ADDR-1:0]  w_waddr [PORTS];
  logic [WIDTH-1:0] w_wdata [PORTS];
  logic [WIDTH-1:0] w_ldata [PORTS];
  logic [WIDTH-1:0] w_rdata [PORTS];
  logic [PORTS-1:0] w_rd, w_wr, w_ld;
  logic             w_collision;

  assign w_run = (r_state == StRun);

  // FSM state register and sweep datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StInit;
      r_ptr   <= '0;
      r_fill  <= OFS;
    end else begin
      r_state <= w_state_d;
      if (r_state == StInit) begin
        r_ptr  <= r_ptr + 1'b1;
        r_fill <= r_fill + INCR;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StInit:  if (r_ptr == ADDR'(DEPTH - 1)) w_state_d = StRun;
      StRun:   w_state_d = StRun;
      default: w_state_d = StInit;
    endcase
  end

  assign o_init_busy = (r_state == StInit);

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    assign w_raddr[p] = i_raddr[p*ADDR +: ADDR];
    assign w_waddr[p] = i_waddr[p*ADDR +: ADDR];
    assign w_wdata[p] = i_wi[p*WIDTH +: WIDTH];
    assign w_ldata[p] = i_ri[p*WIDTH +: WIDTH];
    // A reading port drops its write request entirely.
    assign w_rd[p] = w_run & i_re[p];
    assign w_wr[p] = w_run & i_we[p] & ~i_re[p];
    assign w_ld[p] = w_run & i_ld[p] & ~i_re[p] & ~i_we[p];
    assign o_dout[p*WIDTH +: WIDTH] = r_dout[p];

`ifdef BRAM_FWD_EN
    // Ascending scan so the highest-index writer wins, matching what is stored.
    always_comb begin
      w_rdata[p] = r_mem[w_raddr[p]];
      for (int q = 0; q < int'(PORTS); q++) begin
        if (w_wr[q] && (w_waddr[q] == w_raddr[p])) w_rdata[p] = w_wdata[q];
      end
    end
`else
    assign w_rdata[p] = r_mem[w_raddr[p]];
`endif
  end

  always_comb begin
    w_collision = 1'b0;
    for (int a = 0; a < int'(PORTS); a++) begin
      for (int b = a + 1; b < int'(PORTS); b++) begin
        if (w_wr[a] && w_wr[b] && (w_waddr[a] == w_waddr[b])) w_collision = 1'b1;
      end
    end
  end

  // Storage array: never written on a reset edge. Later ports overwrite
  // earlier ones on an address clash.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == StInit) begin
        r_mem[r_ptr] <= r_fill;
      end else begin
        for (int p = 0; p < int'(PORTS); p++) begin
          if (w_wr[p]) r_mem[w_waddr[p]] <= w_wdata[p];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int p = 0; p < int'(PORTS); p++) r_dout[p] <= '0;
      r_dvalid    <= '0;
      r_collision <= 1'b0;
    end else begin
      r_collision <= w_collision;
      r_dvalid    <= w_rd | w_wr | w_ld;
      for (int p = 0; p < int'(PORTS); p++) begin
        if (w_rd[p])      r_dout[p] <= w_rdata[p];
        else if (w_wr[p]) r_dout[p] <= w_wdata[p];
        else if (w_ld[p]) r_dout[p] <= w_ldata[p];
      end
    end
  end

  assign o_dvalid    = r_dvalid;
  assign o_collision = r_collision;

endmodule

// File: tb/tb_bram_mp.sv
// Self-checking bench for bram_mp (DEPTH=16, WIDTH=8, PORTS=2, OFS=3, INCR=2).
// Hand-written vector table for directed cases, then random traffic compared
// against an array-based reference model.
module tb_bram_mp;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

`ifdef BRAM_FWD_EN
  localparam logic [7:0] EXP_XRW = 8'h99;
`else
  localparam logic [7:0] EXP_XRW = 8'd15;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [1:0]  re, we, ld;
  logic [7:0]  raddr, waddr;
  logic [15:0] wi, ri;
  logic [15:0] dout;
  logic [1:0]  dvalid;
  logic        collision;

  int total = 0;
  int bad   = 0;

  bram_mp #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .PORTS(2), .OFS(8'd3), .INCR(8'd2)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .o_init_busy(busy),
    .i_re(re), .i_we(we), .i_ld(ld),
    .i_raddr(raddr), .i_waddr(waddr), .i_wi(wi), .i_ri(ri),
    .o_dout(dout), .o_dvalid(dvalid), .o_collision(collision)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         mm [DEPTH];
  logic [7:0] md [2];
  logic [1:0] mdv;
  logic       mcol;

  typedef struct {
    logic [1:0] re, we, ld;
    logic [3:0] ra0, ra1, wa0, wa1;
    logic [7:0] wi0, wi1, ri0, ri1;
    logic [7:0] d0, d1;
    logic [1:0] dv;
    logic       col;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    re = '0; we = '0; ld = '0; raddr = '0; waddr = '0; wi = '0; ri = '0;
  endtask

  task automatic rand_in();
    re    = 2'($urandom);
    we    = 2'($urandom);
    ld    = 2'($urandom);
    raddr = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
    waddr = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
    wi    = 16'($urandom);
    ri    = 16'($urandom);
  endtask

  task automatic model_reinit();
    for (int i = 0; i < DEPTH; i++) mm[i] = (3 + 2 * i) % 256;
    md[0] = '0; md[1] = '0; mdv = '0; mcol = 1'b0;
  endtask

  // Spec-level behaviour of one RUN edge, from the currently driven inputs.
  task automatic model_edge();
    int old [DEPTH];
    bit wr [2];
    int ra [2], wa [2], wv [2], rv [2];
    old = mm;
    for (int p = 0; p < 2; p++) begin
      ra[p] = int'(raddr[p*4 +: 4]);
      wa[p] = int'(waddr[p*4 +: 4]);
      wv[p] = int'(wi[p*8 +: 8]);
      rv[p] = int'(ri[p*8 +: 8]);
      wr[p] = we[p] && !re[p];
    end
    mcol = wr[0] && wr[1] && (wa[0] == wa[1]);
    for (int p = 0; p < 2; p++) begin
      mdv[p] = 1'b1;
      if (re[p]) begin
        int v;
        v = old[ra[p]];
`ifdef BRAM_FWD_EN
        for (int q = 0; q < 2; q++) if (wr[q] && wa[q] == ra[p]) v = wv[q];
`endif
        md[p] = 8'(v);
      end else if (wr[p]) begin
        md[p] = 8'(wv[p]);
      end else if (ld[p]) begin
        md[p] = 8'(rv[p]);
      end else begin
        mdv[p] = 1'b0;
      end
    end
    for (int q = 0; q < 2; q++) if (wr[q]) mm[wa[q]] = wv[q];
  endtask

  task automatic run_random(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      rand_in();
      model_edge();
      tick();
      chk($sformatf("%s%0d dout0", tag, i), 32'(dout[7:0]), 32'(md[0]));
      chk($sformatf("%s%0d dout1", tag, i), 32'(dout[15:8]), 32'(md[1]));
      chk($sformatf("%s%0d dvalid", tag, i), 32'(dvalid), 32'(mdv));
      chk($sformatf("%s%0d coll", tag, i), 32'(collision), 32'(mcol));
    end
  endtask

  // Counts edges until init_busy falls, with random requests that must be ignored.
  task automatic sweep(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      rand_in();
      tick();
      n++;
      chk($sformatf("%s dvalid%0d", tag, n), 32'(dvalid), 32'd0);
      chk($sformatf("%s dout%0d", tag, n), 32'(dout), 32'd0);
    end
    chk($sformatf("%s busy_edges", tag), 32'(n), 32'd16);
  endtask

  initial begin
    //        re     we     ld     ra0 ra1 wa0 wa1 wi0    wi1    ri0    ri1    d0     d1     dv     col
    tbl[0]  = '{2'b01, 2'b00, 2'b00, 5,  0,  0,  0,  8'h00, 8'h00, 8'h00, 8'h00, 8'd13, 8'd0,  2'b01, 1'b0};
    tbl[1]  = '{2'b01, 2'b00, 2'b00, 15, 0,  0,  0,  8'h00, 8'h00, 8'h00, 8'h00, 8'd33, 8'd0,  2'b01, 1'b0};
    tbl[2]  = '{2'b01, 2'b01, 2'b00, 2,  0,  2,  0,  8'hAA, 8'h00, 8'h00, 8'h00, 8'd7,  8'd0,  2'b01, 1'b0};
    tbl[3]  = '{2'b01, 2'b00, 2'b00, 2,  0,  0,  0,  8'h00, 8'h00, 8'h00, 8'h00, 8'd7,  8'd0,  2'b01, 1'b0};
    tbl[4]  = '{2'b00, 2'b00, 2'b01, 0,  0,  0,  0,  8'h00, 8'h00, 8'h55, 8'h00, 8'h55, 8'd0,  2'b01, 1'b0};
    tbl[5]  = '{2'b00, 2'b11, 2'b00, 0,  0,  4,  4,  8'h11, 8'h22, 8'h00, 8'h00, 8'h11, 8'h22, 2'b11, 1'b1};
    tbl[6]  = '{2'b00, 2'b00, 2'b00, 0,  0,  0,  0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 2'b00, 1'b0};
    tbl[7]  = '{2'b01, 2'b00, 2'b00, 4,  0,  0,  0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h22, 8'h22, 2'b01, 1'b0};
    tbl[8]  = '{2'b10, 2'b01, 2'b00, 0,  6,  6,  0,  8'h99, 8'h00, 8'h00, 8'h00, 8'h99, EXP_XRW, 2'b11, 1'b0};
    tbl[9]  = '{2'b10, 2'b00, 2'b00, 0,  6,  0,  0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h99, 8'h99, 2'b10, 1'b0};
    tbl[10] = '{2'b01, 2'b11, 2'b00, 0,  0,  7,  7,  8'hEE, 8'h44, 8'h00, 8'h00, 8'd3,  8'h44, 2'b11, 1'b0};
    tbl[11] = '{2'b10, 2'b00, 2'b01, 0,  7,  0,  0,  8'h00, 8'h00, 8'h5A, 8'h00, 8'h5A, 8'h44, 2'b11, 1'b0};
    tbl[12] = '{2'b01, 2'b00, 2'b00, 4,  0,  0,  0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h22, 8'h44, 2'b01, 1'b0};

    idle_in();
    rst = 1'b1;
    tick();
    chk("reset busy", 32'(busy), 32'd1);
    chk("reset dout", 32'(dout), 32'd0);
    chk("reset dvalid", 32'(dvalid), 32'd0);
    chk("reset coll", 32'(collision), 32'd0);
    rst = 1'b0;
    sweep("init");
    model_reinit();

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      re = tbl[i].re; we = tbl[i].we; ld = tbl[i].ld;
      raddr = {tbl[i].ra1, tbl[i].ra0};
      waddr = {tbl[i].wa1, tbl[i].wa0};
      wi = {tbl[i].wi1, tbl[i].wi0};
      ri = {tbl[i].ri1, tbl[i].ri0};
      model_edge();
      tick();
      chk($sformatf("vec%0d dout0", i), 32'(dout[7:0]), 32'(tbl[i].d0));
      chk($sformatf("vec%0d dout1", i), 32'(dout[15:8]), 32'(tbl[i].d1));
      chk($sformatf("vec%0d dvalid", i), 32'(dvalid), 32'(tbl[i].dv));
      chk($sformatf("vec%0d coll", i), 32'(collision), 32'(tbl[i].col));
    end

    // Idle hold after the read of 0x22
    idle_in();
    for (int i = 0; i < 5; i++) begin
      model_edge();
      tick();
      chk($sformatf("hold%0d dout0", i), 32'(dout[7:0]), 32'h22);
      chk($sformatf("hold%0d dvalid0", i), 32'(dvalid[0]), 32'd0);
    end

    run_random(300, "rnd");

    // Reset mid-sweep: restart at pointer 7
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rand_in();
      tick();
      chk($sformatf("mid busy%0d", i), 32'(busy), 32'd1);
      chk($sformatf("mid dvalid%0d", i), 32'(dvalid), 32'd0);
    end
    rand_in();
    rst = 1'b1;
    tick();
    chk("mid rst busy", 32'(busy), 32'd1);
    chk("mid rst dvalid", 32'(dvalid), 32'd0);
    rst = 1'b0;
    sweep("resweep");
    model_reinit();

    // Every word must hold its sweep value again
    idle_in();
    for (int a = 0; a < DEPTH; a++) begin
      re = 2'b10;
      raddr = {4'(a), 4'd0};
      model_edge();
      tick();
      chk($sformatf("sweepval%0d", a), 32'(dout[15:8]), 32'((3 + 2 * a) % 256));
    end

    run_random(150, "rnd2_");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
